// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: RV32 opcodes, format codes,
// buffer occupancy states and the opcode-to-format helper.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Unknown opcodes fall back to I-format so fmt/imm stay well defined.
  function automatic fmt_e fmt_of(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:                f = FMT_U;
      OPC_JAL:                           f = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:    f = FMT_I;
      OPC_STORE:                         f = FMT_S;
      OPC_BRANCH:                        f = FMT_B;
      OPC_OP:                            f = FMT_R;
      default:                           f = FMT_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: instruction word in, format code and
// sign-extended immediate out. Shared with the branch predictor.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] inst,
  output logic [XLEN-1:0]       imm,
  output fmt_e                  fmt
);

  logic [31:0] imm32_s;

  // Pick the format from the opcode and assemble the 32-bit immediate for it.
  always_comb begin
    fmt     = fmt_of(inst[6:0]);
    imm32_s = 32'd0;
    case (fmt)
      FMT_R:   imm32_s = 32'd0;
      FMT_I:   imm32_s = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32_s = {inst[31:12], 12'd0};
      FMT_J:   imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32_s = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  // Every layout carries inst[31] in bit 31, so a signed widen finishes the job.
  assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// Pipelined RV32I/RV32E decode stage. Decodes the offered instruction,
// flags illegal encodings and buffers results in a main + skid register
// pair so in_ready never depends combinationally on out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int INST_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_WIDTH-1:0]     inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [6:0]                op,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [2:0]                fmt,
  output logic [XLEN-1:0]           imm,
  output logic                      illegal
);

  if (INST_WIDTH != 32) begin : g_bad_inst_width
    $error("decode_stage: INST_WIDTH must be 32");
  end
  if (XLEN < 32) begin : g_bad_xlen
    $error("decode_stage: XLEN must be at least 32");
  end

  typedef struct packed {
    logic [6:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    fmt_e                      fmt;
    logic [XLEN-1:0]           imm;
    logic                      illegal;
  } dec_t;

  localparam dec_t DEC_RST = '{
    op: 7'd0, rd: '0, rs1: '0, rs2: '0, funct3: 3'd0, funct7: 7'd0,
    fmt: FMT_I, imm: '0, illegal: 1'b0
  };

  logic [6:0]      opc_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [XLEN-1:0] gen_imm_s;
  fmt_e            gen_fmt_s;
  logic            enc_bad_s;
  logic            use_rd_s;
  logic            use_rs1_s;
  logic            use_rs2_s;
  logic            reg_bad_s;
  logic            illegal_s;
  dec_t            dec_s;

  buf_state_e state_q, state_d;
  dec_t       m_q, m_d;
  dec_t       s_q, s_d;
  logic       accept_s;
  logic       drain_s;

  assign opc_s = inst[6:0];
  assign f3_s  = inst[14:12];
  assign f7_s  = inst[31:25];

  imm_gen #(
    .XLEN       (XLEN),
    .INST_WIDTH (INST_WIDTH)
  ) u_imm_gen (
    .inst (inst),
    .imm  (gen_imm_s),
    .fmt  (gen_fmt_s)
  );

  // Opcode/funct legality: reject unknown opcodes and reserved funct combos.
  always_comb begin
    enc_bad_s = 1'b0;
    case (opc_s)
      OPC_LUI, OPC_AUIPC, OPC_JAL: enc_bad_s = 1'b0;
      OPC_JALR:   enc_bad_s = (f3_s != 3'b000);
      OPC_BRANCH: enc_bad_s = (f3_s == 3'b010) || (f3_s == 3'b011);
      OPC_LOAD:   enc_bad_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      OPC_STORE:  enc_bad_s = (f3_s >= 3'b011);
      OPC_OP: begin
        if (f7_s == 7'b0000000) begin
          enc_bad_s = 1'b0;
        end else if (f7_s == 7'b0100000) begin
          enc_bad_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
        end else begin
          enc_bad_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (f3_s == 3'b001) begin
          enc_bad_s = (f7_s != 7'b0000000);
        end else if (f3_s == 3'b101) begin
          enc_bad_s = !((f7_s == 7'b0000000) || (f7_s == 7'b0100000));
        end else begin
          enc_bad_s = 1'b0;
        end
      end
      default: enc_bad_s = 1'b1;
    endcase
  end

  // Which register fields the format actually reads or writes.
  always_comb begin
    use_rd_s  = 1'b1;
    use_rs1_s = 1'b1;
    use_rs2_s = 1'b0;
    case (gen_fmt_s)
      FMT_R: begin use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      FMT_I: begin use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b0; end
      FMT_S, FMT_B: begin use_rd_s = 1'b0; use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      FMT_U, FMT_J: begin use_rd_s = 1'b1; use_rs1_s = 1'b0; use_rs2_s = 1'b0; end
      default: begin use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b0; end
    endcase
  end

  // A used register index that does not fit REG_ADDR_WIDTH (x16+ on RV32E) is illegal.
  assign reg_bad_s = (use_rd_s  && ((inst[11:7]  >> REG_ADDR_WIDTH) != 5'd0)) ||
                     (use_rs1_s && ((inst[19:15] >> REG_ADDR_WIDTH) != 5'd0)) ||
                     (use_rs2_s && ((inst[24:20] >> REG_ADDR_WIDTH) != 5'd0));

  assign illegal_s = enc_bad_s || reg_bad_s || (inst[1:0] != 2'b11);

  // Assemble the decoded entry; fields are driven even for illegal words.
  always_comb begin
    dec_s         = DEC_RST;
    dec_s.op      = opc_s;
    dec_s.rd      = inst[7  +: REG_ADDR_WIDTH];
    dec_s.rs1     = inst[15 +: REG_ADDR_WIDTH];
    dec_s.rs2     = inst[20 +: REG_ADDR_WIDTH];
    dec_s.funct3  = f3_s;
    dec_s.funct7  = f7_s;
    dec_s.fmt     = gen_fmt_s;
    dec_s.imm     = gen_imm_s;
    dec_s.illegal = illegal_s;
  end

  // Handshake outputs depend only on the registered occupancy state.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    case (state_q)
      ST_EMPTY: begin out_valid = 1'b0; in_ready = 1'b1; end
      ST_ONE:   begin out_valid = 1'b1; in_ready = 1'b1; end
      ST_FULL:  begin out_valid = 1'b1; in_ready = 1'b0; end
      default:  begin out_valid = 1'b0; in_ready = 1'b1; end
    endcase
  end

  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid && out_ready;

  // Occupancy next state; flush empties the buffer whatever else happens.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !drain_s) begin
            state_d = ST_FULL;
          end else if (!accept_s && drain_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: state_d = drain_s ? ST_ONE : ST_FULL;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Data movement between input decode, skid and main registers.
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          m_d = dec_s;
        end else begin
          m_d = m_q;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          m_d = dec_s;
        end else if (accept_s) begin
          s_d = dec_s;
        end else begin
          m_d = m_q;
        end
      end
      ST_FULL: begin
        if (drain_s) begin
          m_d = s_q;
        end else begin
          m_d = m_q;
        end
      end
      default: begin
        m_d = m_q;
        s_d = s_q;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= DEC_RST;
      s_q <= DEC_RST;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign op      = m_q.op;
  assign rd      = m_q.rd;
  assign rs1     = m_q.rs1;
  assign rs2     = m_q.rs2;
  assign funct3  = m_q.funct3;
  assign funct7  = m_q.funct7;
  assign fmt     = m_q.fmt;
  assign imm     = m_q.imm;
  assign illegal = m_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I/RV32E instruction decode stage with valid/ready handshakes on both sides. It sits between fetch and the register-read/execute stage, and it is the successor to the purely combinational decoder. It adds:
- registered outputs with a skid buffer;
- parametrised data and register-file width;
- store-format decode;
- illegal-instruction detection;
- a pipeline flush.

## Interface
Parameters:
- XLEN, 32: immediate/data width; legal values ≥ 32.
- REG_ADDR_WIDTH, 5: 5 = RV32I (x0–x31); 4 = RV32E (x0–x15).
- INST_WIDTH, 32: instruction width; fixed at 32, other values are a compile-time error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  drop all held instructions this cycle.
- in_valid  in  1  fetch offers inst.
- in_ready  out  1  stage accepts inst this cycle.
- inst  in  INST_WIDTH  instruction word.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  downstream accepts.
- op  out  7  inst[6:0].
- rd, rs1, rs2  out  REG_ADDR_WIDTH each  register indices, from inst[11:7], inst[19:15], inst[24:20], truncated to REG_ADDR_WIDTH.
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- fmt  out  3  format code: R, I, S, B, U, J.
- imm  out  XLEN  sign-extended immediate.
- illegal  out  1  instruction not legal under the parameters.

## Operation
Immediate selection by opcode:
- LUI 0110111 and AUIPC 0010111: U-format. imm = {inst[31:12], 12'b0}, sign-extended to XLEN.
- JAL 1101111: J-format.
- JALR 1100111, LOAD 0000011, OP_IMM 0010011: I-format.
- STORE 0100011: S-format.
- BRANCH 1100011: B-format.
- OP 0110011: R-format, imm = 0.
- All immediates are sign-extended from inst[31].

illegal = 1 when any of the following hold:
- inst[1:0] ≠ 11.
- Opcode is not one of the nine listed above.
- JALR with funct3 ≠ 000.
- BRANCH with funct3 ∈ {010, 011}.
- LOAD with funct3 ∈ {011, 110, 111}.
- STORE with funct3 ≥ 011.
- OP with funct7 ∉ {0000000, 0100000}, or funct7 = 0100000 with funct3 ∉ {000, 101}.
- OP_IMM with funct3 = 001 and funct7 ≠ 0.
- OP_IMM with funct3 = 101 and funct7 ∉ {0000000, 0100000}.
- REG_ADDR_WIDTH = 4 and bit 4 of any used register field is set. Used fields by format:
  - R: rd, rs1, rs2.
  - I: rd, rs1.
  - S and B: rs1, rs2.
  - U and J: rd.

When illegal = 1, all fields are still driven from the instruction word, and fmt/imm follow the opcode table (default I).

Buffering uses a two-entry arrangement:
- Main output register (M) drives the outputs.
- Skid register (S) holds one extra decoded entry.
- in_ready = !S_valid (registered; no combinational path from out_ready).

State, from (M_valid, S_valid):
- EMPTY (0,0).
- ONE (1,0).
- FULL (1,1).

Transitions (accept = in_valid & in_ready; drain = out_valid & out_ready):
- EMPTY + accept → ONE; the decode is loaded into M.
- ONE + accept, no drain → FULL; the decode is loaded into S.
- ONE + accept + drain → ONE; the new decode is loaded into M.
- ONE + drain only → EMPTY.
- FULL + drain → ONE; S moves to M. No accept is possible in FULL.

Flush:
- flush = 1 clears M_valid and S_valid at the next edge, regardless of accept or drain in that cycle.
- An instruction accepted in the flush cycle is discarded.

## Timing
- Latency: inst accepted at edge N appears on out_valid after edge N.
- Throughput: one instruction per cycle when out_ready is held high.
- Reset: out_valid = 0, in_ready = 1, every data output = 0, fmt = I, illegal = 0, both entries invalid.
- Reset deasserted mid-transfer: the stage restarts EMPTY, and no partial entry survives.
- Output stability: while out_valid = 1 and out_ready = 0, all outputs hold stable.
- Downstream stall: out_ready may drop at any time. in_ready falls one cycle after the stage becomes FULL.
- Input side: in_valid may change while in_ready = 0; nothing is captured.

## Structure
- decode_pkg holds:
  - the opcode constants;
  - the fmt enum: R=0, I=1, S=2, B=3, U=4, J=5;
  - a packed decoded-instruction struct (fields above, XLEN-parametrised via a struct in module scope or a max-width field).
- imm_gen is the single sub-module: combinational, taking inst and returning imm and fmt. It is reused later by the branch predictor.
- The legality check and the skid buffer live in decode_stage.

## Test plan
- Reset then stream, out_ready = 1: ADDI x1,x0,-1 (0xFFF00093) → one cycle later op = 0010011, rd = 1, imm = 0xFFFFFFFF, fmt = I, illegal = 0.
- Stream with a stall: SW x2,8(x1) (0x0020A423) then BEQ (0x00208463), with out_ready low for 3 cycles → in_ready low after FULL; SW has imm = 8, fmt = S, and is delivered first; BEQ follows with imm = 8, fmt = B; no loss or duplication.
- Legality: 0x4000F033 (OP with funct7 0100000 and funct3 111) → illegal = 1; 0x00000000 → illegal = 1; LUI 0x12345037 → imm = 0x12345000, illegal = 0.
- RV32E, REG_ADDR_WIDTH = 4: ADD x16,x1,x2 (0x00208833) → illegal = 1. The same instruction with REG_ADDR_WIDTH = 5 → rd = 16, illegal = 0.
- Flush in FULL with a concurrent in_valid → next cycle out_valid = 0 and in_ready = 1.
- Reset asserted in FULL → out_valid = 0 immediately (asynchronous); after release, the stream resumes from EMPTY.
